// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle fetch/decode/execute/writeback sequencer for the 16-bit ALU
//
// Fetches 32-bit instructions over a req/ack port and reads operands from a
// register file with combinational read and synchronous write. It drives the
// external combinational ALU, samples its outputs, and writes results back.
// It owns pc and the carry/bool/zero architectural flags.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      restart pulse, honoured in IDLE/HALT only
//   imem_req/addr/ack/data     instruction fetch handshake
//   rf_ra1/ra2, rf_rd1/rd2     register read port (rs1/rs2)
//   rf_we/wa/wd                register write port (rd)
//   alu_opcode/r1/r2/imm       ALU operand outputs
//   alu_acc/carry/bool         ALU result inputs
//   carry/bool/zero_flag       architectural flags
//   pc, busy, halted, illegal  status
module alu_sequencer #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] START_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_data,
  output logic [2:0]      rf_ra1,
  output logic [2:0]      rf_ra2,
  input  logic [15:0]     rf_rd1,
  input  logic [15:0]     rf_rd2,
  output logic            rf_we,
  output logic [2:0]      rf_wa,
  output logic [15:0]     rf_wd,
  output logic [4:0]      alu_opcode,
  output logic [15:0]     alu_r1,
  output logic [15:0]     alu_r2,
  output logic [15:0]     alu_imm,
  input  logic [15:0]     alu_acc,
  input  logic            alu_carry,
  input  logic            alu_bool,
  output logic            carry_flag,
  output logic            bool_flag,
  output logic            zero_flag,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic            illegal
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [4:0] OP_LAST_ALU = 5'd14;
  localparam logic [4:0] OP_CMP_LO   = 5'd5;
  localparam logic [4:0] OP_CMP_HI   = 5'd8;
  localparam logic [4:0] OP_BRB      = 5'd15;
  localparam logic [4:0] OP_JMP      = 5'd16;
  localparam logic [4:0] OP_HALT     = 5'd31;

  state_t      state;
  logic [4:0]  op;
  logic [2:0]  rd;
  logic [15:0] imm;

  logic is_alu;
  logic is_cmp;
  logic op_sets_carry;
  logic [PC_W-1:0] pc_next_seq;
  logic [PC_W-1:0] imm_target;

  // Instruction bits [17:16] carry no meaning.
  logic unused_bits;
  assign unused_bits = ^imem_data[17:16];

  assign imem_addr     = pc;
  assign is_alu        = (op <= OP_LAST_ALU);
  assign is_cmp        = (op >= OP_CMP_LO) && (op <= OP_CMP_HI);
  assign op_sets_carry = (op <= 5'd1);
  assign pc_next_seq   = pc + 1'b1;
  assign imm_target    = imm[PC_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= START_PC;
      op         <= '0;
      rd         <= '0;
      imm        <= '0;
      imem_req   <= 1'b0;
      rf_ra1     <= '0;
      rf_ra2     <= '0;
      rf_we      <= 1'b0;
      rf_wa      <= '0;
      rf_wd      <= '0;
      alu_opcode <= '0;
      alu_r1     <= '0;
      alu_r2     <= '0;
      alu_imm    <= '0;
      carry_flag <= 1'b0;
      bool_flag  <= 1'b0;
      zero_flag  <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pc       <= START_PC;
            state    <= S_FETCH;
            imem_req <= 1'b1;
            busy     <= 1'b1;
          end
        end

        S_FETCH: begin
          if (imem_ack) begin
            op       <= imem_data[31:27];
            rd       <= imem_data[26:24];
            rf_ra1   <= imem_data[23:21];
            rf_ra2   <= imem_data[20:18];
            imm      <= imem_data[15:0];
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end
        end

        // The ALU operand registers double as the latched operands.
        S_DECODE: begin
          alu_opcode <= op;
          alu_r1     <= rf_rd1;
          alu_r2     <= rf_rd2;
          alu_imm    <= imm;
          state      <= S_EXEC;
        end

        // Only the ALU outputs the opcode defines are sampled; the rest are stale.
        S_EXEC: begin
          if (is_alu && is_cmp) begin
            bool_flag <= alu_bool;
            pc        <= pc_next_seq;
            state     <= S_FETCH;
            imem_req  <= 1'b1;
          end else if (is_alu) begin
            rf_we     <= 1'b1;
            rf_wa     <= rd;
            rf_wd     <= alu_acc;
            zero_flag <= (alu_acc == 16'h0000);
            if (op_sets_carry) begin
              carry_flag <= alu_carry;
            end
            state <= S_WB;
          end else if (op == OP_BRB) begin
            pc       <= bool_flag ? imm_target : pc_next_seq;
            state    <= S_FETCH;
            imem_req <= 1'b1;
          end else if (op == OP_JMP) begin
            pc       <= imm_target;
            state    <= S_FETCH;
            imem_req <= 1'b1;
          end else begin
            // HALT or undefined opcode: pc stays on the halting instruction.
            illegal <= (op != OP_HALT);
            halted  <= 1'b1;
            busy    <= 1'b0;
            state   <= S_HALT;
          end
        end

        S_WB: begin
          rf_we    <= 1'b0;
          pc       <= pc_next_seq;
          state    <= S_FETCH;
          imem_req <= 1'b1;
        end

        S_HALT: begin
          if (start) begin
            pc       <= START_PC;
            illegal  <= 1'b0;
            halted   <= 1'b0;
            busy     <= 1'b1;
            imem_req <= 1'b1;
            state    <= S_FETCH;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer
module tb_alu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [2:0]  rf_ra1, rf_ra2;
  logic [15:0] rf_rd1, rf_rd2;
  logic        rf_we;
  logic [2:0]  rf_wa;
  logic [15:0] rf_wd;
  logic [4:0]  alu_opcode;
  logic [15:0] alu_r1, alu_r2, alu_imm;
  logic [15:0] alu_acc;
  logic        alu_carry, alu_bool;
  logic        carry_flag, bool_flag, zero_flag;
  logic [7:0]  pc;
  logic        busy, halted, illegal;

  int n_tests = 0;
  int n_fail  = 0;

  alu_sequencer #(.PC_W(8), .START_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .alu_opcode(alu_opcode), .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_imm(alu_imm),
    .alu_acc(alu_acc), .alu_carry(alu_carry), .alu_bool(alu_bool),
    .carry_flag(carry_flag), .bool_flag(bool_flag), .zero_flag(zero_flag),
    .pc(pc), .busy(busy), .halted(halted), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stub: 0 ADD, 2 SUB, 3 MUL, 4 pass r1, 7 CMPEQI. SUB/MUL/CMP drive
  // carry=1 and CMP drives acc=DEAD so undue sampling shows in the flags.
  function automatic logic [17:0] alu_model(input logic [4:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic [15:0] im);
    logic [16:0] s;
    logic [17:0] r;
    r = '0;
    s = {1'b0, a} + {1'b0, b};
    case (op)
      5'd0:    r = {1'b0, s};
      5'd2:    r = {2'b01, a - b};
      5'd3:    r = {2'b01, a * b};
      5'd4:    r = {2'b00, a};
      5'd7:    r = {(a == im), 1'b1, 16'hDEAD};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign {alu_bool, alu_carry, alu_acc} = alu_model(alu_opcode, alu_r1, alu_r2, alu_imm);

  // Register file: combinational read, synchronous write, plus a preload port.
  logic [15:0] regs [8];
  logic        load_en = 1'b0;
  logic [2:0]  load_a  = '0;
  logic [15:0] load_d  = '0;
  assign rf_rd1 = regs[rf_ra1];
  assign rf_rd2 = regs[rf_ra2];
  always @(posedge clk) begin
    if (load_en) regs[load_a] = load_d;
    else if (rf_we) regs[rf_wa] = rf_wd;
  end

  // Instruction memory responder: ack after ack_delay wait cycles.
  logic [31:0] imem [256];
  int          ack_delay = 0;
  logic        force_ack = 1'b0;
  int          wait_cnt;

  function automatic logic [31:0] enc(input int op, input int rd, input int rs1,
                                      input int rs2, input int im);
    return {op[4:0], rd[2:0], rs1[2:0], rs2[2:0], 2'b00, im[15:0]};
  endfunction

  initial begin
    imem_ack  = 1'b0;
    imem_data = '0;
    wait_cnt  = 0;
    forever begin
      @(negedge clk);
      if (force_ack) begin
        imem_ack  = 1'b1;
        imem_data = enc(0, 7, 5, 5, 0);
      end else if (imem_req) begin
        if (wait_cnt == ack_delay) begin
          imem_ack  = 1'b1;
          imem_data = imem[imem_addr];
          wait_cnt  = 0;
        end else begin
          imem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        imem_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  int          cyc, we_cnt, req_cnt, we_at;
  bit          addr_ok;
  logic [2:0]  last_wa;
  logic [15:0] last_wd;

  task automatic load_reg(input int a, input logic [15:0] d);
    @(negedge clk);
    load_a  = a[2:0];
    load_d  = d;
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Runs from the first FETCH cycle of one instruction to the first FETCH
  // cycle of the next one (or to HALT), counting cycles.
  task automatic step();
    logic       prev_req;
    logic [7:0] a0;
    bit         done;
    cyc = 0; we_cnt = 0; req_cnt = 1; we_at = 0; addr_ok = 1'b1; done = 1'b0;
    prev_req = 1'b1;
    a0 = imem_addr;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (rf_we) begin
        we_cnt++; we_at = cyc; last_wa = rf_wa; last_wd = rf_wd;
      end
      if (imem_req && prev_req) begin
        req_cnt++;
        if (imem_addr !== a0) addr_ok = 1'b0;
      end
      if ((imem_req && !prev_req) || halted) begin
        done = 1'b1;
        break;
      end
      prev_req = imem_req;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL step_timeout: no next fetch or halt within 40 cycles (pc=%h)", pc);
      cyc = 999;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_tests++; if (pc !== 8'h00) begin n_fail++; $display("FAIL rst_pc: got %h want 00", pc); end
    n_tests++; if ({carry_flag, bool_flag, zero_flag, halted, illegal, rf_we} !== 6'b0) begin
      n_fail++; $display("FAIL rst_flags: got %b want 000000", {carry_flag, bool_flag, zero_flag, halted, illegal, rf_we}); end
    n_tests++; if ({alu_opcode, alu_r1, alu_r2, alu_imm} !== 53'h0) begin
      n_fail++; $display("FAIL rst_alu: got %h want 0", {alu_opcode, alu_r1, alu_r2, alu_imm}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_start_ignored: busy got %b want 0", busy); end
  endtask

  task automatic test_add();
    for (int i = 0; i < 8; i++) load_reg(i, 16'h0000);
    load_reg(1, 16'hFFFF);
    load_reg(2, 16'h0002);
    load_reg(4, 16'h0007);
    imem[0] = enc(0, 3, 1, 2, 0);
    imem[1] = enc(31, 0, 0, 0, 0);
    pulse_start();
    n_tests++; if (imem_req !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL add_fetch: req/busy got %b%b want 11", imem_req, busy); end
    step();
    n_tests++; if (cyc !== 4) begin n_fail++; $display("FAIL add_latency: got %0d want 4", cyc); end
    n_tests++; if (we_cnt !== 1 || we_at !== 3) begin n_fail++; $display("FAIL add_we: count %0d at %0d want 1 at 3", we_cnt, we_at); end
    n_tests++; if (last_wa !== 3'd3 || last_wd !== 16'h0001) begin n_fail++; $display("FAIL add_wb: wa=%0d wd=%h want 3/0001", last_wa, last_wd); end
    n_tests++; if (carry_flag !== 1'b1 || zero_flag !== 1'b0) begin n_fail++; $display("FAIL add_flags: c=%b z=%b want 1/0", carry_flag, zero_flag); end
    n_tests++; if (pc !== 8'h01) begin n_fail++; $display("FAIL add_pc: got %h want 01", pc); end
    step();
    n_tests++; if (halted !== 1'b1 || illegal !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL halt_state: h/i/b got %b%b%b want 100", halted, illegal, busy); end
    n_tests++; if (cyc !== 3 || pc !== 8'h01) begin n_fail++; $display("FAIL halt_pc: cyc %0d pc %h want 3/01", cyc, pc); end
  endtask

  task automatic test_sub_mul();
    imem[0] = enc(2, 4, 1, 1, 0);
    imem[1] = enc(3, 5, 4, 2, 0);
    imem[2] = enc(31, 0, 0, 0, 0);
    pulse_start();
    step();
    n_tests++; if (last_wa !== 3'd4 || last_wd !== 16'h0000) begin n_fail++; $display("FAIL sub_wb: wa=%0d wd=%h want 4/0000", last_wa, last_wd); end
    n_tests++; if (zero_flag !== 1'b1 || carry_flag !== 1'b1) begin n_fail++; $display("FAIL sub_flags: z=%b c=%b want 1/1", zero_flag, carry_flag); end
    step();
    n_tests++; if (last_wa !== 3'd5 || last_wd !== 16'h0000) begin n_fail++; $display("FAIL mul_hazard: wa=%0d wd=%h want 5/0000", last_wa, last_wd); end
    n_tests++; if (zero_flag !== 1'b1 || carry_flag !== 1'b1 || cyc !== 4) begin
      n_fail++; $display("FAIL mul_flags: z=%b c=%b cyc=%0d want 1/1/4", zero_flag, carry_flag, cyc); end
    step();
  endtask

  task automatic test_cmp_brb();
    load_reg(6, 16'h0005);
    imem[0]    = enc(7, 0, 6, 0, 5);
    imem[1]    = enc(15, 0, 0, 0, 16'h0020);
    imem[8'h20] = enc(31, 0, 0, 0, 0);
    pulse_start();
    step();
    n_tests++; if (bool_flag !== 1'b1 || pc !== 8'h01 || cyc !== 3 || we_cnt !== 0) begin
      n_fail++; $display("FAIL cmp_true: bool=%b pc=%h cyc=%0d we=%0d want 1/01/3/0", bool_flag, pc, cyc, we_cnt); end
    n_tests++; if (carry_flag !== 1'b1 || zero_flag !== 1'b1) begin
      n_fail++; $display("FAIL cmp_keeps_flags: c=%b z=%b want 1/1", carry_flag, zero_flag); end
    step();
    n_tests++; if (pc !== 8'h20 || cyc !== 3 || we_cnt !== 0) begin
      n_fail++; $display("FAIL brb_taken: pc=%h cyc=%0d we=%0d want 20/3/0", pc, cyc, we_cnt); end
    step();
    imem[0] = enc(7, 0, 6, 0, 6);
    imem[2] = enc(16, 0, 0, 0, 16'h01FF);
    imem[8'hFF] = enc(4, 0, 6, 0, 0);
    pulse_start();
    step();
    n_tests++; if (bool_flag !== 1'b0 || we_cnt !== 0) begin n_fail++; $display("FAIL cmp_false: bool=%b we=%0d want 0/0", bool_flag, we_cnt); end
    step();
    n_tests++; if (pc !== 8'h02 || we_cnt !== 0) begin n_fail++; $display("FAIL brb_not_taken: pc=%h we=%0d want 02/0", pc, we_cnt); end
    step();
    n_tests++; if (pc !== 8'hFF || cyc !== 3) begin n_fail++; $display("FAIL jmp_trunc: pc=%h cyc=%0d want FF/3", pc, cyc); end
    step();
    imem[0] = enc(31, 0, 0, 0, 0);
    n_tests++; if (pc !== 8'h00 || zero_flag !== 1'b0 || last_wd !== 16'h0005) begin
      n_fail++; $display("FAIL pc_wrap: pc=%h z=%b wd=%h want 00/0/0005", pc, zero_flag, last_wd); end
    step();
  endtask

  task automatic test_delay();
    imem[0] = enc(0, 3, 1, 2, 0);
    imem[1] = enc(31, 0, 0, 0, 0);
    ack_delay = 3;
    pulse_start();
    step();
    ack_delay = 0;
    n_tests++; if (cyc !== 7) begin n_fail++; $display("FAIL delay_latency: got %0d want 7", cyc); end
    n_tests++; if (req_cnt !== 4 || addr_ok !== 1'b1) begin n_fail++; $display("FAIL delay_req: cycles %0d stable %b want 4/1", req_cnt, addr_ok); end
    n_tests++; if (last_wd !== 16'h0001) begin n_fail++; $display("FAIL delay_wb: wd=%h want 0001", last_wd); end
    step();
  endtask

  task automatic test_illegal();
    imem[0]     = enc(16, 0, 0, 0, 16'h0010);
    imem[8'h10] = enc(20, 1, 2, 3, 16'h1234);
    pulse_start();
    step();
    step();
    n_tests++; if (halted !== 1'b1 || illegal !== 1'b1 || pc !== 8'h10) begin
      n_fail++; $display("FAIL illegal_halt: h=%b i=%b pc=%h want 1/1/10", halted, illegal, pc); end
    pulse_start();
    n_tests++; if (illegal !== 1'b0 || halted !== 1'b0 || pc !== 8'h00 || imem_req !== 1'b1) begin
      n_fail++; $display("FAIL illegal_restart: i=%b h=%b pc=%h req=%b want 0/0/00/1", illegal, halted, pc, imem_req); end
    step();
    step();
  endtask

  task automatic test_reset_mid_fetch();
    imem[0] = enc(16, 0, 0, 0, 16'h0033);
    pulse_start();
    step();
    ack_delay = 100;
    @(posedge clk);
    #2;
    n_tests++; if (imem_req !== 1'b1 || pc !== 8'h33) begin n_fail++; $display("FAIL mid_pre: req=%b pc=%h want 1/33", imem_req, pc); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (imem_req !== 1'b0 || busy !== 1'b0 || pc !== 8'h00) begin
      n_fail++; $display("FAIL mid_async: req=%b busy=%b pc=%h want 0/0/00", imem_req, busy, pc); end
    n_tests++; if ({carry_flag, bool_flag, zero_flag, halted, illegal, rf_we, alu_opcode} !== 11'b0) begin
      n_fail++; $display("FAIL mid_outputs: got %b want 0", {carry_flag, bool_flag, zero_flag, halted, illegal, rf_we, alu_opcode}); end
    @(negedge clk);
    rst_n = 1'b1;
    ack_delay = 0;
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (imem_req !== 1'b0 || busy !== 1'b0 || pc !== 8'h00 || rf_ra1 !== 3'd0) begin
      n_fail++; $display("FAIL stray_ack: req=%b busy=%b pc=%h ra1=%0d want 0/0/00/0", imem_req, busy, pc, rf_ra1); end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    test_reset();
    test_add();
    test_sub_mul();
    test_cmp_brb();
    test_delay();
    test_illegal();
    test_reset_mid_fetch();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
